// File: rtl/if_stage.sv
// Instruction-fetch stage: pc register, next-pc selection and the IF/ID pipeline register.
// Optional performance counters (stall_cnt, redirect_cnt) are built when IF_STAGE_PERF_CNT_EN is defined.
module if_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        is_jump,
  input  logic [31:0] jump_pc,
  input  logic        branch_taken,
  input  logic [31:0] branch_pc,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_inst,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid
`ifdef IF_STAGE_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] redirect_cnt
`endif
);

  typedef enum logic [1:0] {
    SelSeq,
    SelStall,
    SelJump,
    SelBranch
  } nextSel_e;

  logic [31:0] pcReg;
  logic [31:0] pcPlus4;
  nextSel_e    nextSel;
  logic        isRedirect;

  // 32-bit add drops the carry, so 0xFFFFFFFC rolls over to 0.
  assign pcPlus4   = pcReg + 32'd4;
  assign imem_addr = pcReg;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    nextSel = SelSeq;
    if (branch_taken)  nextSel = SelBranch;
    else if (stall)    nextSel = SelStall;
    else if (is_jump)  nextSel = SelJump;
  end

  assign isRedirect = (nextSel == SelBranch) || (nextSel == SelJump);

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcReg       <= 32'd0;
      if_id_inst  <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
    end else begin
      case (nextSel)
        SelBranch: begin
          pcReg       <= branch_pc;
          if_id_inst  <= 32'd0;
          if_id_pc4   <= 32'd0;
          if_id_valid <= 1'b0;
        end
        SelStall: begin
          // Hold everything; a held J in ID re-asserts is_jump next cycle.
          pcReg       <= pcReg;
          if_id_inst  <= if_id_inst;
          if_id_pc4   <= if_id_pc4;
          if_id_valid <= if_id_valid;
        end
        SelJump: begin
          pcReg       <= jump_pc;
          if_id_inst  <= 32'd0;
          if_id_pc4   <= 32'd0;
          if_id_valid <= 1'b0;
        end
        default: begin
          pcReg       <= pcPlus4;
          if_id_inst  <= imem_data;
          if_id_pc4   <= pcPlus4;
          if_id_valid <= 1'b1;
        end
      endcase
    end
  end

`ifdef IF_STAGE_PERF_CNT_EN
  // Saturating counters; a stall that coincides with a branch is counted as a redirect only.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt    <= 16'd0;
      redirect_cnt <= 16'd0;
    end else begin
      if (nextSel == SelStall && stall_cnt != 16'hFFFF)
        stall_cnt <= stall_cnt + 16'd1;
      if (isRedirect && redirect_cnt != 16'hFFFF)
        redirect_cnt <= redirect_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed self-checking bench for if_stage; inputs change 1 time unit after each rising edge
// and outputs are checked there. Counter checks are compiled in with IF_STAGE_PERF_CNT_EN.
module tb_if_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        is_jump;
  logic [31:0] jump_pc;
  logic        branch_taken;
  logic [31:0] branch_pc;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic [31:0] if_id_inst;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
`ifdef IF_STAGE_PERF_CNT_EN
  logic [15:0] stall_cnt;
  logic [15:0] redirect_cnt;
`endif

  int total = 0;
  int bad   = 0;

  if_stage dut (
    .clk          (clk),
    .rst          (rst),
    .stall        (stall),
    .is_jump      (is_jump),
    .jump_pc      (jump_pc),
    .branch_taken (branch_taken),
    .branch_pc    (branch_pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .if_id_inst   (if_id_inst),
    .if_id_pc4    (if_id_pc4),
    .if_id_valid  (if_id_valid)
`ifdef IF_STAGE_PERF_CNT_EN
    ,
    .stall_cnt    (stall_cnt),
    .redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Instruction memory: fixed words at 0/4/8, otherwise address + 0x10000000.
  always_comb begin
    case (imem_addr)
      32'h0:   imem_data = 32'h11;
      32'h4:   imem_data = 32'h22;
      32'h8:   imem_data = 32'h33;
      default: imem_data = imem_addr + 32'h1000_0000;
    endcase
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_if(input string tag, input logic [31:0] pc, input logic [31:0] inst,
                           input logic [31:0] pc4, input logic valid);
    check({tag, ".pc"}, imem_addr, pc);
    check({tag, ".inst"}, if_id_inst, inst);
    check({tag, ".pc4"}, if_id_pc4, pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, valid});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; is_jump = 1'b0; jump_pc = 32'h0;
    branch_taken = 1'b0; branch_pc = 32'h0;

    // Reset state
    tick();
    expect_if("reset", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
    check("reset.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("reset.redirect_cnt", {16'd0, redirect_cnt}, 32'd0);
`endif

    // Sequential fetch: 0x11, 0x22, 0x33
    rst = 1'b0;
    tick(); expect_if("seq0", 32'h4, 32'h11, 32'h4, 1'b1);
    tick(); expect_if("seq1", 32'h8, 32'h22, 32'h8, 1'b1);
    tick(); expect_if("seq2", 32'hC, 32'h33, 32'hC, 1'b1);

    // Stall two cycles at pc=0xC, then resume fetching 0xC
    stall = 1'b1;
    tick(); expect_if("stall0", 32'hC, 32'h33, 32'hC, 1'b1);
    tick(); expect_if("stall1", 32'hC, 32'h33, 32'hC, 1'b1);
`ifdef IF_STAGE_PERF_CNT_EN
    check("stall.stall_cnt", {16'd0, stall_cnt}, 32'd2);
`endif
    stall = 1'b0;
    tick(); expect_if("resume", 32'h10, 32'h1000_000C, 32'h10, 1'b1);

    // Jump at pc=0x8 to 0x100
    rst = 1'b1;
    tick(); expect_if("rst2", 32'h0, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
    tick(); tick();
    expect_if("prejump", 32'h8, 32'h22, 32'h8, 1'b1);
    is_jump = 1'b1; jump_pc = 32'h100;
    tick(); expect_if("jump", 32'h100, 32'h0, 32'h0, 1'b0);
    is_jump = 1'b0;
    tick(); expect_if("postjump", 32'h104, 32'h1000_0100, 32'h104, 1'b1);
`ifdef IF_STAGE_PERF_CNT_EN
    check("jump.redirect_cnt", {16'd0, redirect_cnt}, 32'd1);
`endif

    // Stall outranks jump: everything holds
    stall = 1'b1; is_jump = 1'b1; jump_pc = 32'h200;
    tick(); expect_if("stalljump", 32'h104, 32'h1000_0100, 32'h104, 1'b1);

    // Branch outranks stall and jump
    branch_taken = 1'b1; branch_pc = 32'h40; jump_pc = 32'h80;
    tick(); expect_if("branch", 32'h40, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
    check("branch.redirect_cnt", {16'd0, redirect_cnt}, 32'd2);
    check("branch.stall_cnt", {16'd0, stall_cnt}, 32'd1);
`endif
    branch_taken = 1'b0; stall = 1'b0; is_jump = 1'b0;
    tick(); expect_if("postbranch", 32'h44, 32'h1000_0040, 32'h44, 1'b1);

    // Unaligned jump target passes through untouched
    is_jump = 1'b1; jump_pc = 32'h0000_0102;
    tick(); check("unaligned.pc", imem_addr, 32'h102);
    is_jump = 1'b0;

    // Wrap: branch to 0xFFFFFFFC, then sequential wraps to 0
    branch_taken = 1'b1; branch_pc = 32'hFFFF_FFFC;
    tick(); expect_if("towrap", 32'hFFFF_FFFC, 32'h0, 32'h0, 1'b0);
    branch_taken = 1'b0;
    tick(); expect_if("wrap", 32'h0, 32'h0FFF_FFFC, 32'h0, 1'b1);
`ifdef IF_STAGE_PERF_CNT_EN
    check("wrap.redirect_cnt", {16'd0, redirect_cnt}, 32'd4);
`endif

    // Reset during a stall with a pending redirect
    tick();
    stall = 1'b1; is_jump = 1'b1; jump_pc = 32'h300; rst = 1'b1;
    tick(); expect_if("rststall", 32'h0, 32'h0, 32'h0, 1'b0);
`ifdef IF_STAGE_PERF_CNT_EN
    check("rststall.stall_cnt", {16'd0, stall_cnt}, 32'd0);
    check("rststall.redirect_cnt", {16'd0, redirect_cnt}, 32'd0);
`endif
    rst = 1'b0; stall = 1'b0; is_jump = 1'b0;
    tick(); expect_if("afterrst", 32'h4, 32'h11, 32'h4, 1'b1);

`ifdef IF_STAGE_PERF_CNT_EN
    // Saturation after 70000 stall cycles
    stall = 1'b1;
    for (int i = 0; i < 70000; i++) @(posedge clk);
    #1;
    check("sat.stall_cnt", {16'd0, stall_cnt}, 32'h0000_FFFF);
    check("sat.pc", imem_addr, 32'h4);
    stall = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/if_stage.md
IF_STAGE -- requirements
Module: if_stage

Interface
REQ-001 SHALL have port clk, input, 1, single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-003 SHALL have port stall, input, 1, load-use hold from hazard unit.
REQ-004 SHALL have port is_jump, input, 1, J decoded in ID this cycle.
REQ-005 SHALL have port jump_pc, input, 32, J target from ID decode.
REQ-006 SHALL have port branch_taken, input, 1, BEQ/BNE resolved taken in MEM.
REQ-007 SHALL have port branch_pc, input, 32, branch target from MEM.
REQ-008 SHALL have port imem_addr, output, 32, combinational instruction-memory address, equal to pc.
REQ-009 SHALL have port imem_data, input, 32, instruction read from imem_addr, same cycle.
REQ-010 SHALL have port if_id_inst, output, 32, registered instruction to ID decode.
REQ-011 SHALL have port if_id_pc4, output, 32, registered PC+4 of if_id_inst.
REQ-012 SHALL have port if_id_valid, output, 1, 0 marks a bubble.

Function
REQ-013 SHALL hold a 32-bit pc register driving imem_addr.
REQ-014 SHALL compute pc+4 modulo 2^32, so 0xFFFFFFFC wraps to 0x00000000.
REQ-015 SHALL pick next-pc by fixed priority: branch_taken, then stall, then is_jump, then sequential.
REQ-016 SHALL, on branch_taken: load pc=branch_pc, set if_id_inst=0, if_id_valid=0, if_id_pc4=0, regardless of stall/is_jump.
REQ-017 SHALL, on stall without branch_taken: hold pc, if_id_inst, if_id_pc4, if_id_valid unchanged, ignoring is_jump (the held J re-asserts next cycle).
REQ-018 SHALL, on is_jump without stall/branch_taken: load pc=jump_pc and squash the fetched slot (if_id_inst=0, if_id_valid=0, if_id_pc4=0).
REQ-019 SHALL, otherwise: load pc=pc+4, if_id_inst=imem_data, if_id_pc4=pc+4, if_id_valid=1.
REQ-020 SHALL give one-cycle fetch latency: instruction at address A appears on if_id_inst the cycle after pc=A.
REQ-021 SHALL pass jump_pc and branch_pc unmodified (no alignment masking).
REQ-022 SHALL encode a bubble as all-zero if_id_inst, decoded downstream as R-type with no ALU operation.

Reset
REQ-023 SHALL, when rst=1 at a clock edge, set pc=0, if_id_inst=0, if_id_pc4=0, if_id_valid=0, overriding all other inputs.
REQ-024 SHALL, on reset mid-stall or mid-redirect, discard the pending redirect; the first fetch after release is address 0.
REQ-025 SHALL fetch address 0 in the first cycle with rst=0, and present it on if_id_inst one cycle later.

Configuration
REQ-026 SHALL, with macro IF_STAGE_PERF_CNT_EN defined, add outputs stall_cnt (16) and redirect_cnt (16).
REQ-027 SHALL increment stall_cnt on each edge where stall=1 and branch_taken=0.
REQ-028 SHALL increment redirect_cnt on each edge where a REQ-016 or REQ-018 redirect is taken.
REQ-029 SHALL make both counters saturate at 0xFFFF and clear to 0 on rst.
REQ-030 SHALL, with IF_STAGE_PERF_CNT_EN undefined, omit both ports and counter logic; all other behaviour is identical.

Verification
REQ-031 SHALL cover sequential fetch: rst 1 cycle, then imem returns 0x11,0x22,0x33 -> if_id_inst 0x11,0x22,0x33 with if_id_pc4 4,8,12 and valid=1.
REQ-032 SHALL cover jump: is_jump=1, jump_pc=0x100 at pc=0x8 -> next pc=0x100, one bubble (inst=0, valid=0), then inst from 0x100 with pc4=0x104.
REQ-033 SHALL cover stall: stall=1 for 2 cycles at pc=0xC -> pc and IF/ID frozen 2 cycles, then fetch resumes at 0xC; stall_cnt=2 when the macro is enabled.
REQ-034 SHALL cover priority: branch_taken=1, branch_pc=0x40, with stall=1 and is_jump=1, jump_pc=0x80 -> pc=0x40, bubble, redirect_cnt +1.
REQ-035 SHALL cover wrap and reset: pc=0xFFFFFFFC sequential -> pc=0, if_id_pc4=0; rst asserted during a stall -> all outputs 0, counters 0.
REQ-036 SHALL cover saturation: 70000 stall cycles with the macro enabled -> stall_cnt=0xFFFF.
